// File: rtl/irq_ctrl_if.sv
// CSR-file / commit-side signals of the interrupt controller.
// The master drives the CSR strobes and enables; the slave is irq_ctrl.
interface irq_ctrl_if;
    logic [1:0]  swi;
    logic [1:0]  swi_clr;
    logic        ti;
    logic        ti_clr;
    logic        crmd_ie;
    logic [12:0] ecfg_lie;
    logic        int_taken;
    logic [12:0] is;
    logic        int_req;
    logic [3:0]  int_vec;

    modport master (
        output swi, swi_clr, ti, ti_clr, crmd_ie, ecfg_lie, int_taken,
        input  is, int_req, int_vec
    );

    modport slave (
        input  swi, swi_clr, ti, ti_clr, crmd_ie, ecfg_lie, int_taken,
        output is, int_req, int_vec
    );
endinterface

// File: rtl/irq_ctrl.sv
// ESTAT.IS collector: synchronizes HWI/IPI, latches SWI/TI, and raises a masked
// interrupt request with a one-cycle block after each take.
module irq_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] hwi,
    input  logic       ipi,
    irq_ctrl_if.slave  bus
);
    localparam logic [12:0] IS_RSVD = 13'h0400;

    logic [SYNC_STAGES-1:0][8:0] sync_q;
    logic [1:0]                  swi_q;
    logic                        ti_q;
    logic                        blk_q;
    logic [12:0]                 is_w;
    logic [12:0]                 pend;
    logic                        req_w;
    logic [3:0]                  vec_w;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours; blocking here would collapse the
    // synchronizer chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            swi_q  <= '0;
            ti_q   <= 1'b0;
            blk_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], {ipi, hwi}};
            swi_q  <= (swi_q | bus.swi) & ~bus.swi_clr;
            // A fresh expiry beats a simultaneous clear so it is never lost.
            ti_q   <= bus.ti | (ti_q & ~bus.ti_clr);
            // The CSR exception write drops CRMD.IE on the next edge, so one cycle suffices.
            blk_q  <= bus.int_taken & req_w;
        end
    end

    assign is_w  = {sync_q[SYNC_STAGES-1][8], ti_q, 1'b0,
                    sync_q[SYNC_STAGES-1][7:0], swi_q};
    assign pend  = is_w & bus.ecfg_lie & ~IS_RSVD;
    assign req_w = bus.crmd_ie & (|pend) & ~blk_q;

    // NOTE: the default is assigned before the loop so every path writes vec_w
    // and no latch is inferred.
    always_comb begin
        vec_w = '0;
        for (int i = 0; i < 13; i++) begin
            if (pend[i]) vec_w = 4'(i);
        end
    end

    assign bus.is      = is_w;
    assign bus.int_req = req_w;
    assign bus.int_vec = vec_w;
endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: scoreboard of expected {is, int_req, int_vec}
// pushed with each stimulus step and popped when the outputs are sampled.
module tb_irq_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] hwi, hwi3;
    logic       ipi, ipi3;

    irq_ctrl_if bus ();
    irq_ctrl_if bus3 ();

    irq_ctrl #(.SYNC_STAGES(2)) u_dut  (.clk(clk), .rst_n(rst_n), .hwi(hwi),  .ipi(ipi),  .bus(bus));
    irq_ctrl #(.SYNC_STAGES(3)) u_dut3 (.clk(clk), .rst_n(rst_n), .hwi(hwi3), .ipi(ipi3), .bus(bus3));

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [12:0] is;
        logic        req;
        logic [3:0]  vec;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input string n, input logic [12:0] i, input logic r, input logic [3:0] v);
        exp_t x;
        x.name = n; x.is = i; x.req = r; x.vec = v;
        sb.push_back(x);
    endtask

    // One rising edge, then land on the following falling edge for sampling/driving.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        hwi = 8'hFF; ipi = 1'b0; hwi3 = '0; ipi3 = 1'b0;
        bus.swi = '0; bus.swi_clr = '0; bus.ti = 1'b1; bus.ti_clr = 1'b0;
        bus.crmd_ie = 1'b1; bus.ecfg_lie = 13'h1FFF; bus.int_taken = 1'b0;
        bus3.swi = '0; bus3.swi_clr = '0; bus3.ti = 1'b0; bus3.ti_clr = 1'b0;
        bus3.crmd_ie = 1'b0; bus3.ecfg_lie = '0; bus3.int_taken = 1'b0;
        push("reset_hold", 13'h0000, 1'b0, 4'd0);
        repeat (3) cyc();
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
        bus.ti = 1'b0; bus.crmd_ie = 1'b0; bus.ecfg_lie = '0;
        rst_n = 1'b1;
        push("reset_edge1", 13'h0000, 1'b0, 4'd0);
        push("reset_edge2", 13'h03FC, 1'b0, 4'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            e = sb.pop_front(); checks++;
            if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
                failures++;
                $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
            end
        end
        hwi = 8'h00;
        cyc(); cyc();
    endtask

    task automatic test_swi();
        bus.ecfg_lie = 13'h002; bus.crmd_ie = 1'b1;
        bus.swi = 2'b10;
        push("swi_set", 13'h0002, 1'b1, 4'd1);
        cyc(); bus.swi = '0;
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
        bus.swi_clr = 2'b10;
        push("swi_clr", 13'h0000, 1'b0, 4'd0);
        cyc(); bus.swi_clr = '0;
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
        bus.ecfg_lie = 13'h003;
        bus.swi = 2'b01;
        push("swi0_set", 13'h0001, 1'b1, 4'd0);
        cyc(); bus.swi = '0;
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
        bus.swi = 2'b01; bus.swi_clr = 2'b01;
        push("swi_collide_clr_wins", 13'h0000, 1'b0, 4'd0);
        cyc(); bus.swi = '0; bus.swi_clr = '0;
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
    endtask

    task automatic test_ti();
        bus.ecfg_lie = 13'h0800; bus.crmd_ie = 1'b1;
        bus.ti = 1'b1;
        push("ti_set", 13'h0800, 1'b1, 4'd11);
        cyc(); bus.ti = 1'b0;
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
        bus.ti = 1'b1; bus.ti_clr = 1'b1;
        push("ti_collide_set_wins", 13'h0800, 1'b1, 4'd11);
        cyc(); bus.ti = 1'b0; bus.ti_clr = 1'b0;
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
        bus.ti_clr = 1'b1;
        push("ti_clr", 13'h0000, 1'b0, 4'd0);
        cyc(); bus.ti_clr = 1'b0;
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
    endtask

    task automatic test_priority();
        bus.ecfg_lie = 13'h1FFF; bus.crmd_ie = 1'b1;
        hwi = 8'h01; bus.ti = 1'b1;
        push("prio_ti_only", 13'h0800, 1'b1, 4'd11);
        push("prio_ti_hwi0", 13'h0804, 1'b1, 4'd11);
        push("prio_lie_004", 13'h0804, 1'b1, 4'd2);
        push("prio_lie_none", 13'h0804, 1'b0, 4'd0);
        push("prio_ie_off", 13'h0804, 1'b0, 4'd11);
        cyc(); bus.ti = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k == 1) cyc();
            if (k == 2) begin bus.ecfg_lie = 13'h004; #1; end
            if (k == 3) begin bus.ecfg_lie = 13'h000; #1; end
            if (k == 4) begin bus.ecfg_lie = 13'h1FFF; bus.crmd_ie = 1'b0; #1; end
            e = sb.pop_front(); checks++;
            if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
                failures++;
                $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
            end
        end
        @(negedge clk);
        hwi = 8'h00; bus.ti_clr = 1'b1;
        cyc(); bus.ti_clr = 1'b0;
        cyc();
    endtask

    task automatic test_take();
        bus.ecfg_lie = 13'h1FFF; bus.crmd_ie = 1'b1;
        bus.swi = 2'b01;
        cyc(); bus.swi = '0;
        bus.int_taken = 1'b1; #1;
        push("take_same_cycle", 13'h0001, 1'b1, 4'd0);
        push("take_blocked", 13'h0001, 1'b0, 4'd0);
        push("take_reassert", 13'h0001, 1'b1, 4'd0);
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin cyc(); bus.int_taken = 1'b0; end
            e = sb.pop_front(); checks++;
            if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
                failures++;
                $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
            end
        end
        @(negedge clk);
        bus.crmd_ie = 1'b0; bus.int_taken = 1'b1;
        cyc(); bus.int_taken = 1'b0; bus.crmd_ie = 1'b1; #1;
        push("take_ignored", 13'h0001, 1'b1, 4'd0);
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        bus.int_taken = 1'b1;
        push("b2b_blocked", 13'h0001, 1'b0, 4'd0);
        push("b2b_reassert", 13'h0001, 1'b1, 4'd0);
        for (int k = 0; k < 2; k++) begin
            cyc();
            if (k == 1) bus.int_taken = 1'b0;
            e = sb.pop_front(); checks++;
            if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
                failures++;
                $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
            end
        end
        bus.int_taken = 1'b0;
        bus.ti = 1'b1;
        cyc(); bus.ti = 1'b0;
        #2 rst_n = 1'b0; #1;
        push("async_reset_mid", 13'h0000, 1'b0, 4'd0);
        e = sb.pop_front(); checks++;
        if ({bus.is, bus.int_req, bus.int_vec} !== {e.is, e.req, e.vec}) begin
            failures++;
            $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus.is, bus.int_req, bus.int_vec, e.is, e.req, e.vec);
        end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_sync3();
        hwi3 = 8'h20;
        push("sync3_rise_e1", 13'h0000, 1'b0, 4'd0);
        push("sync3_rise_e2", 13'h0000, 1'b0, 4'd0);
        push("sync3_rise_e3", 13'h0080, 1'b0, 4'd0);
        push("sync3_fall_e1", 13'h0080, 1'b0, 4'd0);
        push("sync3_fall_e2", 13'h0080, 1'b0, 4'd0);
        push("sync3_fall_e3", 13'h0000, 1'b0, 4'd0);
        for (int k = 0; k < 6; k++) begin
            cyc();
            if (k == 2) hwi3 = 8'h00;
            e = sb.pop_front(); checks++;
            if ({bus3.is, bus3.int_req, bus3.int_vec} !== {e.is, e.req, e.vec}) begin
                failures++;
                $display("FAIL %s: is=%h req=%b vec=%0d expected is=%h req=%b vec=%0d", e.name, bus3.is, bus3.int_req, bus3.int_vec, e.is, e.req, e.vec);
            end
        end
    endtask

    initial begin
        test_reset();
        test_swi();
        test_ti();
        test_priority();
        test_take();
        test_back_to_back();
        test_sync3();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Interrupt status collector and request generator that sits directly upstream of the CSR file. It owns ESTAT.IS:
- synchronizes the asynchronous hardware and IPI lines;
- latches the software- and timer-interrupt events that the CSR file reports on `swi`/`swi_clr` and `ti`/`ti_clr`;
- drives the 13-bit `is` vector the CSR file folds into ESTAT.

It also masks `is` with ECFG.LIE and CRMD.IE and raises a single interrupt request toward the exception/commit logic. A taken-interrupt handshake suppresses re-requests until the CSR exception write has landed.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flop depth of the synchronizer on `hwi` and `ipi` (legal 2..4).

Ports:
- `clk`  in  1  core clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `hwi`  in  8  external hardware interrupt lines; asynchronous, level-sensitive.
- `ipi`  in  1  inter-processor interrupt line; asynchronous, level-sensitive.
- `swi`  in  2  software-interrupt set strobes from the CSR file (ESTAT write).
- `swi_clr`  in  2  software-interrupt clear strobes from the CSR file.
- `ti`  in  1  timer-expiry pulse from the CSR file.
- `ti_clr`  in  1  TICLR.CLR write strobe from the CSR file.
- `crmd_ie`  in  1  current CRMD.IE.
- `ecfg_lie`  in  13  current ECFG.LIE.
- `int_taken`  in  1  commit stage is taking the interrupt this cycle; only valid while `int_req`=1.
- `is`  out  13  ESTAT.IS to the CSR file.
- `int_req`  out  1  an enabled interrupt is pending.
- `int_vec`  out  4  index of the highest-numbered pending enabled bit (debug/perf use).

## Operation
- `is` bit map:
  - [1:0] SWI, latched.
  - [9:2] HWI0..7, synchronized level, not latched.
  - [10] constant 0.
  - [11] TI, latched.
  - [12] IPI, synchronized level.
- SWI latch, per bit i: `is[i] <= (is[i] | swi[i]) & ~swi_clr[i]`.
  - `swi` and `swi_clr` are never both 1 for the same bit.
  - If they are, clear wins.
- TI latch: set on `ti`, cleared on `ti_clr`. Set wins when both are 1 in the same cycle, so a new expiry is never lost.
- HWI/IPI synchronizer: `SYNC_STAGES` flops per line, no edge detection. The last flop output drives `is` directly.
- `pend = is & ecfg_lie`, with bit 10 forced 0.
- `int_req = crmd_ie & |pend & ~blk`.
- `blk` register:
  - Set on `int_taken & int_req`.
  - Cleared the following cycle, because the CSR exception write clears CRMD.IE on that edge.
  - Therefore `int_req` is 0 for exactly one cycle after a take. After that, `crmd_ie` gates it.
- `int_taken` while `int_req`=0 is ignored and does not set `blk`.
- `int_vec`: highest set index in `pend` (12 down to 0); 0 when `pend`=0.
- Combinational paths from `crmd_ie`/`ecfg_lie` to `int_req`/`int_vec` are allowed. There are none from `int_taken`.

## Timing
- Reset (async assert): all synchronizer flops, the SWI/TI latches and `blk` go to 0, so `is`=0, `int_req`=0 and `int_vec`=0 immediately.
- Reset release: first state update occurs on the first rising edge with `rst_n`=1.
- `swi`/`ti` strobe in cycle N: `is` bit visible in cycle N+1. `int_req` is high in N+1 if it is enabled.
- `hwi`/`ipi` change: visible in `is` after `SYNC_STAGES` rising edges (2 by default). A deassert takes the same latency.
- `int_taken` in cycle N: `int_req`=0 in N+1 regardless of inputs. It may reassert in N+2 if `crmd_ie`=1 (e.g. an `ertn` committed).
- Reset mid-operation drops latched SWI/TI. This is intended.

## Test plan
- Reset: hold `rst_n`=0 with `hwi`=8'hFF and `ti`=1 → `is`=0 and `int_req`=0. Release → `is[9:2]`=8'hFF two edges later.
- SWI: `swi`=2'b10 for one cycle with `ecfg_lie`=13'h002 and `crmd_ie`=1 → next cycle `is`=13'h002, `int_req`=1, `int_vec`=1. Then `swi_clr`=2'b10 → `is`=0 and `int_req`=0 the next cycle.
- TI collision: `ti`=1 and `ti_clr`=1 in the same cycle while `is[11]`=1 → `is[11]` stays 1. Then `ti_clr` alone → `is[11]`=0.
- Priority: `is` has bits 2 and 11 set with `ecfg_lie`=13'h1FFF → `int_vec`=11. Set `ecfg_lie`=13'h004 → `int_vec`=2, `int_req`=1.
- Take handshake: `int_req`=1, pulse `int_taken` while holding `crmd_ie`=1 → `int_req`=0 for exactly one cycle, then 1 again. `int_taken` pulsed while `int_req`=0 → no change.
- HWI latency with `SYNC_STAGES`=3: `hwi[5]` rises → `is[7]` rises on the 3rd edge. `hwi[5]` falls → `is[7]` falls on the 3rd edge.
